// File: rtl/pcie_csr_mc.sv
// Multi-port PCIe CSR feature: DFH, link status, sticky error capture with
// first-error index, and a sideband command channel to the PCIe SS.
//
// state | meaning
// IDLE  | no command outstanding, SS_CMD writes may launch
// ISSUE | command driven to the SS, waiting for ack or timeout
// DONE  | one-cycle retire, command field cleared
module pcie_csr_mc #(
  parameter int          ADDR_WIDTH      = 19,
  parameter int          DATA_WIDTH      = 64,
  parameter int          NUM_PORTS       = 1,
  parameter int          NUM_ERR         = 34,
  parameter int          SS_ADDR_WIDTH   = 20,
  parameter int          TIMEOUT_CYC     = 4096,
  parameter logic [11:0] FEAT_ID         = 12'h0,
  parameter logic [3:0]  FEAT_VER        = 4'h0,
  parameter logic [23:0] NEXT_DFH_OFFSET = 24'h1000,
  parameter logic        END_OF_LIST     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csr_write,
  input  logic [ADDR_WIDTH-1:0]    csr_waddr,
  input  logic [DATA_WIDTH-1:0]    csr_wdata,
  input  logic [1:0]               csr_write_type,
  input  logic                     csr_read,
  input  logic [ADDR_WIDTH-1:0]    csr_raddr,
  input  logic                     csr_read_32b,
  output logic [DATA_WIDTH-1:0]    csr_readdata,
  output logic                     csr_readdata_valid,
  input  logic [NUM_PORTS-1:0]     i_linkup,
  input  logic [NUM_ERR-1:0]       i_err,
  output logic [1:0]               o_ss_ctrl_cmd,
  output logic [SS_ADDR_WIDTH-1:0] o_ss_ctrl_addr,
  output logic [31:0]              o_ss_ctrl_writedata,
  input  logic                     i_ss_ack,
  input  logic                     i_ss_error,
  input  logic [31:0]              i_ss_readdata,
  output logic                     o_err_any
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [63:0] DFH = {4'h3, 8'h0, 4'h0, 7'h0, END_OF_LIST,
                                 NEXT_DFH_OFFSET, FEAT_VER, FEAT_ID};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} ss_state_t;

  ss_state_t state, state_nxt;

  logic [63:0]              scratch;
  logic [NUM_ERR-1:0]       err_mask, err;
  logic                     first_valid;
  logic [5:0]               first_idx;
  logic [1:0]               ss_cmd;
  logic [SS_ADDR_WIDTH-1:0] ss_addr;
  logic                     ss_ack, ss_err, ss_tmo, ss_ovr;
  logic [31:0]              ss_wrdata, ss_rddata;
  logic [1:0]               lat_cmd;
  logic [SS_ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]              lat_wdata;
  logic [CW-1:0]            cnt;
  logic [NUM_PORTS-1:0]     link_s1, link_s2;

  // Write decode: only the low 0x40 bytes are implemented; write type picks the lanes.
  logic        wr_hit;
  logic [2:0]  wr_sel;
  logic [63:0] wmask;
  assign wr_hit = csr_write && (csr_waddr[ADDR_WIDTH-1:6] == '0);
  assign wr_sel = csr_waddr[5:3];

  // Lane mask from write type; 2'b11 is treated as a full write.
  always_comb begin
    wmask = '1;
    case (csr_write_type)
      2'b01:   wmask = {{32{1'b1}}, 32'h0};
      2'b10:   wmask = {32'h0, {32{1'b1}}};
      default: wmask = '1;
    endcase
  end

  logic wr_cmd_lo, wr_cmd_hi, launch_req, launch, ack_evt, tmo_evt;
  assign wr_cmd_lo  = wr_hit && (wr_sel == 3'd6) && wmask[0];
  assign wr_cmd_hi  = wr_hit && (wr_sel == 3'd6) && wmask[32];
  assign launch_req = wr_cmd_lo && (csr_wdata[1:0] != 2'b00) && (csr_wdata[1:0] != 2'b11);
  assign launch     = launch_req && (state == S_IDLE);
  assign ack_evt    = (state == S_ISSUE) && i_ss_ack;
  assign tmo_evt    = (state == S_ISSUE) && !i_ss_ack && (cnt == CNT_LAST);

  // Error capture: new unmasked errors win over a coincident W1C of the same bit.
  logic [NUM_ERR-1:0] err_w1c, err_new, err_keep, err_nxt;
  always_comb begin
    err_w1c  = (wr_hit && wr_sel == 3'd4) ? (csr_wdata[NUM_ERR-1:0] & wmask[NUM_ERR-1:0]) : '0;
    err_new  = i_err & ~err_mask;
    err_keep = err & ~err_w1c;
    err_nxt  = err_keep | err_new;
  end

  function automatic logic [5:0] lowest_idx(input logic [NUM_ERR-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_ERR - 1; i >= 0; i--)
      if (v[i]) lowest_idx = 6'(i);
  endfunction

  // Plain RW registers, sticky errors, first-error capture and the registered error summary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch     <= '0;
      err_mask    <= '0;
      err         <= '0;
      first_valid <= 1'b0;
      first_idx   <= '0;
      o_err_any   <= 1'b0;
    end else begin
      if (wr_hit && wr_sel == 3'd1) scratch <= (scratch & ~wmask) | (csr_wdata & wmask);
      if (wr_hit && wr_sel == 3'd3)
        err_mask <= (err_mask & ~wmask[NUM_ERR-1:0]) | (csr_wdata[NUM_ERR-1:0] & wmask[NUM_ERR-1:0]);
      err       <= err_nxt;
      o_err_any <= |err_nxt;
      // A W1C that empties ERR while a new error lands reloads rather than clears.
      if (err_new != '0 && err_keep == '0) begin
        first_valid <= 1'b1;
        first_idx   <= lowest_idx(err_new);
      end else if (err_nxt == '0) begin
        first_valid <= 1'b0;
        first_idx   <= '0;
      end
    end
  end

  // Two-flop synchroniser for the per-port linkup levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_s1 <= '0;
      link_s2 <= '0;
    end else begin
      link_s1 <= i_linkup;
      link_s2 <= link_s1;
    end
  end

  // Sideband FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Sideband FSM next-state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch) state_nxt = S_ISSUE;
      S_ISSUE: if (i_ss_ack || cnt == CNT_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sideband registers: launch latches a private copy so later CSR writes cannot disturb the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_cmd    <= '0;
      ss_addr   <= '0;
      ss_ack    <= 1'b0;
      ss_err    <= 1'b0;
      ss_tmo    <= 1'b0;
      ss_ovr    <= 1'b0;
      ss_wrdata <= '0;
      ss_rddata <= '0;
      lat_cmd   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
    end else begin
      if (wr_cmd_hi) ss_addr <= csr_wdata[32 +: SS_ADDR_WIDTH];
      if (wr_hit && wr_sel == 3'd7 && wmask[32]) ss_wrdata <= csr_wdata[63:32];
      if (launch_req && state != S_IDLE) ss_ovr <= 1'b1;
      else if (wr_cmd_lo && csr_wdata[6])  ss_ovr <= 1'b0;
      if (launch) begin
        ss_cmd    <= csr_wdata[1:0];
        ss_ack    <= 1'b0;
        ss_err    <= 1'b0;
        ss_tmo    <= 1'b0;
        lat_cmd   <= csr_wdata[1:0];
        lat_addr  <= wr_cmd_hi ? csr_wdata[32 +: SS_ADDR_WIDTH] : ss_addr;
        lat_wdata <= ss_wrdata;
        cnt       <= '0;
      end
      if (state == S_ISSUE) cnt <= cnt + 1'b1;
      if (ack_evt) begin
        ss_ack <= 1'b1;
        ss_err <= i_ss_error;
        if (lat_cmd == 2'b01) ss_rddata <= i_ss_readdata;
      end
      if (tmo_evt) ss_tmo <= 1'b1;
      if (state == S_DONE) ss_cmd <= '0;
    end
  end

  assign o_ss_ctrl_cmd       = (state == S_ISSUE) ? lat_cmd   : '0;
  assign o_ss_ctrl_addr      = (state == S_ISSUE) ? lat_addr  : '0;
  assign o_ss_ctrl_writedata = (state == S_ISSUE) ? lat_wdata : '0;

  // Read mux; out-of-range offsets return zero.
  logic [63:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (csr_raddr[ADDR_WIDTH-1:6] == '0) begin
      case (csr_raddr[5:3])
        3'd0: rd_word = DFH;
        3'd1: rd_word = scratch;
        3'd2: rd_word[NUM_PORTS-1:0] = link_s2;
        3'd3: rd_word[NUM_ERR-1:0] = err_mask;
        3'd4: rd_word[NUM_ERR-1:0] = err;
        3'd5: rd_word = {first_valid, 57'h0, first_idx};
        3'd6: begin
          rd_word[1:0] = ss_cmd;
          rd_word[2]   = (state == S_ISSUE);
          rd_word[3]   = ss_ack;
          rd_word[4]   = ss_err;
          rd_word[5]   = ss_tmo;
          rd_word[6]   = ss_ovr;
          rd_word[32 +: SS_ADDR_WIDTH] = ss_addr;
        end
        default: rd_word = {ss_wrdata, ss_rddata};
      endcase
    end
  end

  // Two-stage read pipeline; a 32b read returns the addressed half in the low lane.
  logic        rd1_valid;
  logic [63:0] rd1_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_valid          <= 1'b0;
      rd1_data           <= '0;
      csr_readdata_valid <= 1'b0;
      csr_readdata       <= '0;
    end else begin
      rd1_valid <= csr_read;
      if (!csr_read)        rd1_data <= '0;
      else if (!csr_read_32b) rd1_data <= rd_word;
      else if (csr_raddr[2])  rd1_data <= {32'h0, rd_word[63:32]};
      else                    rd1_data <= {32'h0, rd_word[31:0]};
      csr_readdata_valid <= rd1_valid;
      csr_readdata       <= rd1_data;
    end
  end

endmodule

// File: tb/tb_pcie_csr_mc.sv
// Directed bench for pcie_csr_mc: register map, error capture, sideband FSM.
module tb_pcie_csr_mc;
  localparam logic [1:0] FULL = 2'b00, UPPER = 2'b01, LOWER = 2'b10;
  localparam logic [63:0] DFH_EXP = 64'h3000_0000_1000_0000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        csr_write = 0, csr_read = 0, csr_read_32b = 0;
  logic [18:0] csr_waddr = '0, csr_raddr = '0;
  logic [63:0] csr_wdata = '0, csr_readdata;
  logic [1:0]  csr_write_type = FULL;
  logic        csr_readdata_valid;
  logic [0:0]  i_linkup = '0;
  logic [33:0] i_err = '0;
  logic [1:0]  o_ss_ctrl_cmd;
  logic [19:0] o_ss_ctrl_addr;
  logic [31:0] o_ss_ctrl_writedata;
  logic        i_ss_ack = 0, i_ss_error = 0;
  logic [31:0] i_ss_readdata = '0;
  logic        o_err_any;

  int n_chk = 0, n_fail = 0;
  logic [63:0] rd;
  int n;

  pcie_csr_mc #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .csr_write(csr_write), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_write_type(csr_write_type),
    .csr_read(csr_read), .csr_raddr(csr_raddr), .csr_read_32b(csr_read_32b),
    .csr_readdata(csr_readdata), .csr_readdata_valid(csr_readdata_valid),
    .i_linkup(i_linkup), .i_err(i_err),
    .o_ss_ctrl_cmd(o_ss_ctrl_cmd), .o_ss_ctrl_addr(o_ss_ctrl_addr),
    .o_ss_ctrl_writedata(o_ss_ctrl_writedata),
    .i_ss_ack(i_ss_ack), .i_ss_error(i_ss_error), .i_ss_readdata(i_ss_readdata),
    .o_err_any(o_err_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic csr_wr(input logic [18:0] a, input logic [63:0] d, input logic [1:0] t);
    @(negedge clk);
    csr_write = 1; csr_waddr = a; csr_wdata = d; csr_write_type = t;
    @(negedge clk);
    csr_write = 0; csr_wdata = '0; csr_write_type = FULL;
  endtask

  // Read with 2-cycle latency check: idle/zero one cycle after, valid the next.
  task automatic csr_rd(input logic [18:0] a, input logic b32, output logic [63:0] d);
    @(negedge clk);
    csr_read = 1; csr_raddr = a; csr_read_32b = b32;
    @(negedge clk);
    csr_read = 0; csr_read_32b = 0;
    chk("rd_valid_early", {63'h0, csr_readdata_valid}, 64'h0);
    @(negedge clk);
    chk("rd_valid", {63'h0, csr_readdata_valid}, 64'h1);
    d = csr_readdata;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd", {62'h0, o_ss_ctrl_cmd}, 64'h0);
    chk("rst_err_any", {63'h0, o_err_any}, 64'h0);
    rst = 0;
    @(negedge clk);
    chk("rst_rdata", csr_readdata, 64'h0);
    csr_rd(19'h00, 0, rd); chk("dfh", rd, DFH_EXP);
    for (int i = 1; i < 8; i++) begin
      csr_rd(19'(i * 8), 0, rd); chk("rst_reg", rd, 64'h0);
    end

    // Scratch full/half writes, 32b reads, out-of-range
    csr_wr(19'h08, 64'h1111_2222_3333_4444, FULL);
    csr_wr(19'h08, 64'hAAAA_BBBB_CCCC_DDDD, LOWER);
    csr_rd(19'h08, 0, rd); chk("scr_lo", rd, 64'h1111_2222_CCCC_DDDD);
    csr_wr(19'h08, 64'hAAAA_BBBB_0000_0000, UPPER);
    csr_rd(19'h08, 0, rd); chk("scr_hi", rd, 64'hAAAA_BBBB_CCCC_DDDD);
    csr_rd(19'h0C, 1, rd); chk("scr_rd32_hi", rd, 64'h0000_0000_AAAA_BBBB);
    csr_rd(19'h08, 1, rd); chk("scr_rd32_lo", rd, 64'h0000_0000_CCCC_DDDD);
    csr_wr(19'h48, 64'h5555_5555_5555_5555, FULL);
    csr_rd(19'h48, 0, rd); chk("oor_read", rd, 64'h0);
    csr_rd(19'h08, 0, rd); chk("oor_no_alias", rd, 64'hAAAA_BBBB_CCCC_DDDD);

    // Link status through synchroniser
    i_linkup = 1'b1;
    repeat (3) @(negedge clk);
    csr_rd(19'h10, 0, rd); chk("stat", rd, 64'h1);

    // Errors: two sources same cycle, lowest index wins
    @(negedge clk); i_err = 34'h24;
    @(negedge clk); i_err = '0;
    chk("err_any_set", {63'h0, o_err_any}, 64'h1);
    csr_rd(19'h20, 0, rd); chk("err_24", rd, 64'h24);
    csr_rd(19'h28, 0, rd); chk("first_2", rd, 64'h8000_0000_0000_0002);
    csr_wr(19'h20, 64'h4, FULL);
    csr_rd(19'h20, 0, rd); chk("err_20", rd, 64'h20);
    csr_rd(19'h28, 0, rd); chk("first_keep", rd, 64'h8000_0000_0000_0002);
    csr_wr(19'h20, 64'h20, FULL);
    csr_rd(19'h28, 0, rd); chk("first_clr", rd, 64'h0);
    chk("err_any_clr", {63'h0, o_err_any}, 64'h0);

    // Masking and set-beats-clear
    csr_wr(19'h18, 64'h4, FULL);
    @(negedge clk); i_err = 34'h4;
    @(negedge clk); i_err = '0;
    csr_rd(19'h20, 0, rd); chk("err_masked", rd, 64'h0);
    @(negedge clk); i_err = 34'h8;
    @(negedge clk); i_err = '0;
    csr_rd(19'h28, 0, rd); chk("first_3", rd, 64'h8000_0000_0000_0003);
    @(negedge clk);
    csr_write = 1; csr_waddr = 19'h20; csr_wdata = 64'h8; csr_write_type = FULL; i_err = 34'h8;
    @(negedge clk);
    csr_write = 0; csr_wdata = '0; i_err = '0;
    csr_rd(19'h20, 0, rd); chk("err_set_wins", rd, 64'h8);
    csr_rd(19'h28, 0, rd); chk("first_3_keep", rd, 64'h8000_0000_0000_0003);

    // Sideband read with ack and overrun
    csr_wr(19'h30, 64'h0000_0123_0000_0001, FULL);
    chk("ss_cmd_rd", {62'h0, o_ss_ctrl_cmd}, 64'h1);
    chk("ss_addr", {44'h0, o_ss_ctrl_addr}, 64'h123);
    csr_wr(19'h30, 64'h0000_0456_0000_0002, FULL);
    chk("ovr_cmd_hold", {62'h0, o_ss_ctrl_cmd}, 64'h1);
    chk("ovr_addr_hold", {44'h0, o_ss_ctrl_addr}, 64'h123);
    repeat (3) @(negedge clk);
    i_ss_ack = 1; i_ss_readdata = 32'hCAFE_F00D;
    @(negedge clk);
    i_ss_ack = 0; i_ss_readdata = '0;
    @(negedge clk);
    chk("ss_idle", {62'h0, o_ss_ctrl_cmd}, 64'h0);
    csr_rd(19'h38, 0, rd); chk("ss_rddata", rd, 64'h0000_0000_CAFE_F00D);
    csr_rd(19'h30, 0, rd); chk("ss_stat_ack_ovr", rd, 64'h0000_0456_0000_0048);
    csr_wr(19'h30, 64'h40, LOWER);
    csr_rd(19'h30, 0, rd); chk("ovr_w1c", rd, 64'h0000_0456_0000_0008);

    // Sideband write with timeout
    csr_wr(19'h38, 64'hDEAD_BEEF_0000_0000, UPPER);
    csr_wr(19'h30, 64'h0000_0077_0000_0002, FULL);
    chk("ss_wdata", {32'h0, o_ss_ctrl_writedata}, 64'hDEAD_BEEF);
    n = 0;
    while (o_ss_ctrl_cmd == 2'b10 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_hold_cycles", 64'(n), 64'd16);
    i_ss_ack = 1; i_ss_readdata = 32'h0BAD_0BAD;
    repeat (2) @(negedge clk);
    i_ss_ack = 0; i_ss_readdata = '0;
    csr_rd(19'h30, 0, rd); chk("ss_stat_tmo", rd, 64'h0000_0077_0000_0020);
    csr_rd(19'h38, 0, rd); chk("late_ack_ignored", rd, 64'hDEAD_BEEF_CAFE_F00D);

    // cmd 2'b11 does not launch
    csr_wr(19'h30, 64'h3, LOWER);
    chk("cmd11_nolaunch", {62'h0, o_ss_ctrl_cmd}, 64'h0);
    csr_rd(19'h30, 0, rd); chk("cmd11_stat", rd, 64'h0000_0077_0000_0020);

    // Reset mid-ISSUE, then relaunch
    csr_wr(19'h30, 64'h0000_0009_0000_0001, FULL);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_abort_cmd", {62'h0, o_ss_ctrl_cmd}, 64'h0);
    @(negedge clk);
    rst = 0;
    csr_rd(19'h30, 0, rd); chk("rst_ss_cmd", rd, 64'h0);
    csr_wr(19'h30, 64'h0000_0005_0000_0001, FULL);
    chk("relaunch_cmd", {62'h0, o_ss_ctrl_cmd}, 64'h1);
    chk("relaunch_addr", {44'h0, o_ss_ctrl_addr}, 64'h5);
    i_ss_ack = 1; i_ss_readdata = 32'h1234_5678;
    @(negedge clk);
    i_ss_ack = 0; i_ss_readdata = '0;
    csr_rd(19'h38, 0, rd); chk("relaunch_rd", rd, 64'h0000_0000_1234_5678);
    csr_rd(19'h30, 0, rd); chk("relaunch_stat", rd, 64'h0000_0005_0000_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
